// File: rtl/interrupt_controller.sv
// Prioritised vectored interrupt controller. Latches rising edges on the
// external lines as pending bits, selects the lowest-index unmasked pending
// source, raises INT with its handler vector and tracks the in-service
// interrupt through an int_ack / eoi handshake (no nesting).
module interrupt_controller #(
    parameter int unsigned NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4,
    parameter int unsigned ID_W       = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               INT,
    output logic [31:0]        vector,
    output logic [ID_W-1:0]    active_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    sel_id;
    logic               any_eligible;
    logic               do_select;
    logic               do_ack;
    logic               do_eoi;

    // Lowest set index wins; scanning downward lets the lowest overwrite last.
    function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_SRC-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = ID_W'(i);
            end
        end
        return id;
    endfunction

    assign rise         = irq_in & ~irq_prev;
    assign eligible     = pending & ~mask;
    assign any_eligible = |eligible;
    assign sel_id       = lowest_index(eligible);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one interrupt in flight at a time.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_eligible) state_next = REQ;
            REQ:     if (int_ack)      state_next = SERVICE;
            SERVICE: if (eoi)          state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Output decode: handshake events and the pending clear for the acked source.
    always_comb begin
        do_select = (state == IDLE) && any_eligible;
        do_ack    = (state == REQ) && int_ack;
        do_eoi    = (state == SERVICE) && eoi;
        clr       = do_ack ? (NUM_SRC'(1) << active_id) : '0;
    end

    // Edge history, pending latch (set beats clear) and mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // Request / service outputs; vector and id hold until the next selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            INT        <= 1'b0;
            vector     <= '0;
            active_id  <= '0;
            in_service <= 1'b0;
        end else begin
            if (do_select) begin
                INT       <= 1'b1;
                vector    <= VEC_BASE + 32'(sel_id) * 32'(VEC_STRIDE);
                active_id <= sel_id;
            end
            if (do_ack) begin
                INT        <= 1'b0;
                in_service <= 1'b1;
            end
            if (do_eoi) begin
                in_service <= 1'b0;
            end
        end
    end

endmodule
